// File: rtl/axil_reg_slave.sv
// AXI4-Lite responder for a small bank of 32-bit control registers.
// Independent single-outstanding write and read engines; all outputs registered.
module axil_reg_slave #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t                 wstate_q;
    rstate_t                 rstate_q;
    logic                    awready_q, wready_q, bvalid_q;
    logic [1:0]              bresp_q;
    logic                    awHave_q, wHave_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic                    arready_q, rvalid_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

    logic                    awFire, wFire, arFire, wrCommit, wrHit, rdHit;
    logic [ADDR_WIDTH-1:0]   wrAddr;
    logic [DATA_WIDTH-1:0]   wrData, rdWord;
    logic [STRB_W-1:0]       wrStrb;
    logic [IDX_W-1:0]        wrIdx, rdIdx;
    logic                    unused_addr_lsbs;

    // A field arriving on this very edge takes precedence over the held copy.
    always_comb begin
        awFire   = s_awvalid && awready_q;
        wFire    = s_wvalid && wready_q;
        arFire   = s_arvalid && arready_q;
        wrAddr   = awFire ? s_awaddr : awaddr_q;
        wrData   = wFire ? s_wdata : wdata_q;
        wrStrb   = wFire ? s_wstrb : wstrb_q;
        wrIdx    = wrAddr[ADDR_WIDTH-1:2];
        rdIdx    = s_araddr[ADDR_WIDTH-1:2];
        wrCommit = (wstate_q == W_IDLE) && (awHave_q || awFire) && (wHave_q || wFire);
        wrHit    = 1'b0;
        rdHit    = 1'b0;
        rdWord   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wrIdx == IDX_W'(i)) wrHit = 1'b1;
            if (rdIdx == IDX_W'(i)) begin
                rdHit  = 1'b1;
                rdWord = regs_q[i];
            end
        end
    end

    assign unused_addr_lsbs = ^{wrAddr[1:0], s_araddr[1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awHave_q  <= 1'b0;
            wHave_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (wrCommit) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            for (int k = 0; k < STRB_W; k++) begin
                                if (wrIdx == IDX_W'(i) && wrStrb[k])
                                    regs_q[i][8*k +: 8] <= wrData[8*k +: 8];
                            end
                        end
                        bresp_q   <= wrHit ? RESP_OKAY : RESP_SLVERR;
                        bvalid_q  <= 1'b1;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        awHave_q  <= 1'b0;
                        wHave_q   <= 1'b0;
                        wstate_q  <= W_RESP;
                    end else begin
                        if (awFire) begin
                            awaddr_q  <= s_awaddr;
                            awHave_q  <= 1'b1;
                            awready_q <= 1'b0;
                        end else begin
                            awready_q <= !awHave_q;
                        end
                        if (wFire) begin
                            wdata_q  <= s_wdata;
                            wstrb_q  <= s_wstrb;
                            wHave_q  <= 1'b1;
                            wready_q <= 1'b0;
                        end else begin
                            wready_q <= !wHave_q;
                        end
                    end
                end
                W_RESP: begin
                    if (s_bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read data comes from the pre-edge register contents, so a same-edge write is not seen.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (arFire) begin
                        rdata_q   <= rdWord;
                        rresp_q   <= rdHit ? RESP_OKAY : RESP_SLVERR;
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : gen_regs_out
        assign regs_out[DATA_WIDTH*g +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: vector table, directed corner sequences,
// and randomized traffic checked against an array model of the register bank.
module tb_axil_reg_slave;

    localparam int AW    = 4;
    localparam int NREGS = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic [AW-1:0]    s_awaddr = '0;
    logic             s_awvalid = 1'b0;
    logic             s_awready;
    logic [31:0]      s_wdata = '0;
    logic [3:0]       s_wstrb = '0;
    logic             s_wvalid = 1'b0;
    logic             s_wready;
    logic [1:0]       s_bresp;
    logic             s_bvalid;
    logic             s_bready = 1'b0;
    logic [AW-1:0]    s_araddr = '0;
    logic             s_arvalid = 1'b0;
    logic             s_arready;
    logic [31:0]      s_rdata;
    logic [1:0]       s_rresp;
    logic             s_rvalid;
    logic             s_rready = 1'b0;
    logic [NREGS*32-1:0] regs_out;

    int total = 0;
    int bad   = 0;
    logic [31:0] model [NREGS];

    typedef struct {
        bit          isWrite;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  expResp;
        logic [31:0] expData;
    } vec_t;

    axil_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .NUM_REGS(NREGS)) dut (
        .clk(clk), .rstn(rstn),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regs_out(regs_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout expected handshake", name);
    endtask

    task automatic checkRegs(input string name);
        for (int i = 0; i < NREGS; i++)
            checkOutput(name, regs_out[32*i +: 32], model[i]);
    endtask

    function automatic logic [1:0] modelWrite(input logic [3:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
        int idx = int'(addr) / 4;
        if (idx >= NREGS) return 2'b10;
        for (int k = 0; k < 4; k++)
            if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
        return 2'b00;
    endfunction

    // Called at a negedge; returns at a negedge after the B handshake.
    task automatic applyWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                              input int awDelay, input int wDelay, input int bDelay,
                              output logic [1:0] resp);
        bit awDone = 0, wDone = 0, awHs, wHs;
        int cyc = 0;
        while (!(awDone && wDone) && cyc < 100) begin
            if (!awDone && cyc >= awDelay) begin s_awvalid = 1'b1; s_awaddr = addr; end
            if (!wDone && cyc >= wDelay) begin s_wvalid = 1'b1; s_wdata = data; s_wstrb = strb; end
            awHs = s_awvalid && s_awready;
            wHs  = s_wvalid && s_wready;
            @(negedge clk);
            cyc++;
            if (awHs) begin s_awvalid = 1'b0; awDone = 1; end
            if (wHs) begin s_wvalid = 1'b0; wDone = 1; end
        end
        resp = 2'bxx;
        if (!(awDone && wDone)) begin
            s_awvalid = 1'b0;
            s_wvalid  = 1'b0;
            reportTimeout("aw_w_handshake");
            return;
        end
        checkOutput("bvalid_latency", s_bvalid, 1'b1);
        repeat (bDelay) @(negedge clk);
        cyc = 0;
        while (!s_bvalid && cyc < 100) begin @(negedge clk); cyc++; end
        if (!s_bvalid) begin reportTimeout("b_handshake"); return; end
        resp = s_bresp;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checkOutput("bvalid_clear", s_bvalid, 1'b0);
    endtask

    task automatic applyRead(input logic [3:0] addr, input int arDelay, input int rDelay,
                             output logic [31:0] data, output logic [1:0] resp);
        bit done = 0, hs;
        int cyc = 0;
        while (!done && cyc < 100) begin
            if (cyc >= arDelay) begin s_arvalid = 1'b1; s_araddr = addr; end
            hs = s_arvalid && s_arready;
            @(negedge clk);
            cyc++;
            if (hs) begin s_arvalid = 1'b0; done = 1; end
        end
        data = 'x;
        resp = 2'bxx;
        if (!done) begin s_arvalid = 1'b0; reportTimeout("ar_handshake"); return; end
        checkOutput("rvalid_latency", s_rvalid, 1'b1);
        repeat (rDelay) @(negedge clk);
        data = s_rdata;
        resp = s_rresp;
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        checkOutput("rvalid_clear", s_rvalid, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v, input int n);
        logic [1:0]  resp;
        logic [31:0] data;
        if (v.isWrite) begin
            applyWrite(v.addr, v.data, v.strb, 0, 0, 0, resp);
            void'(modelWrite(v.addr, v.data, v.strb));
            checkOutput($sformatf("vec%0d_bresp", n), resp, v.expResp);
            checkRegs($sformatf("vec%0d_regs", n));
        end else begin
            applyRead(v.addr, 0, 0, data, resp);
            checkOutput($sformatf("vec%0d_rdata", n), data, v.expData);
            checkOutput($sformatf("vec%0d_rresp", n), resp, v.expResp);
        end
    endtask

    task automatic doReset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        checkOutput("rst_awready", s_awready, 1'b0);
        checkOutput("rst_arready", s_arready, 1'b0);
        checkOutput("rst_bvalid", s_bvalid, 1'b0);
        checkOutput("rst_rvalid", s_rvalid, 1'b0);
        checkOutput("rst_rdata", s_rdata, 32'h0);
        checkRegs("rst_regs");
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rel_awready", s_awready, 1'b1);
        checkOutput("rel_wready", s_wready, 1'b1);
        checkOutput("rel_arready", s_arready, 1'b1);
    endtask

    initial begin
        vec_t        vecs [11];
        logic [1:0]  resp, expResp;
        logic [31:0] data, expData, heldData;
        logic [3:0]  addr;
        int          idx;

        vecs[0]  = '{1, 4'h4, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{0, 4'h4, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{0, 4'h5, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[3]  = '{1, 4'h8, 32'hAAAAAAAA, 4'hF, 2'b00, 32'h0};
        vecs[4]  = '{1, 4'hC, 32'h11111111, 4'hF, 2'b10, 32'h0};
        vecs[5]  = '{0, 4'hC, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[6]  = '{1, 4'h0, 32'h55667788, 4'h5, 2'b00, 32'h0};
        vecs[7]  = '{0, 4'h0, 32'h0,        4'h0, 2'b00, 32'h00660088};
        vecs[8]  = '{0, 4'h8, 32'h0,        4'h0, 2'b00, 32'hAAAAAAAA};
        vecs[9]  = '{1, 4'h4, 32'h0,        4'h0, 2'b00, 32'h0};
        vecs[10] = '{0, 4'h4, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};

        @(negedge clk);
        doReset();

        for (int n = 0; n < 11; n++) applyStimulus(vecs[n], n);
        checkOutput("reg1_out", regs_out[63:32], 32'hDEADBEEF);

        // W three cycles ahead of AW, partial strobe on reg2
        s_wvalid = 1'b1; s_wdata = 32'h12345678; s_wstrb = 4'h3;
        @(negedge clk);
        s_wvalid = 1'b0;
        checkOutput("early_w_wready", s_wready, 1'b0);
        checkOutput("early_w_awready", s_awready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("early_w_reg2_hold", regs_out[95:64], 32'hAAAAAAAA);
        checkOutput("early_w_no_b", s_bvalid, 1'b0);
        s_awvalid = 1'b1; s_awaddr = 4'h8;
        @(negedge clk);
        s_awvalid = 1'b0;
        checkOutput("early_w_reg2", regs_out[95:64], 32'hAAAA5678);
        checkOutput("early_w_bvalid", s_bvalid, 1'b1);
        checkOutput("early_w_bresp", s_bresp, 2'b00);
        model[2] = 32'hAAAA5678;
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("early_w_single_b", s_bvalid, 1'b0);
        end

        // Read and write commit on the same edge to reg0
        applyWrite(4'h0, 32'h1, 4'hF, 0, 0, 0, resp);
        model[0] = 32'h1;
        s_awvalid = 1'b1; s_awaddr = 4'h0; s_wvalid = 1'b1; s_wdata = 32'h2; s_wstrb = 4'hF;
        s_arvalid = 1'b1; s_araddr = 4'h0;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        model[0] = 32'h2;
        checkOutput("race_rvalid", s_rvalid, 1'b1);
        checkOutput("race_rdata_old", s_rdata, 32'h1);
        checkOutput("race_bvalid", s_bvalid, 1'b1);
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        applyRead(4'h0, 0, 0, data, resp);
        checkOutput("race_rdata_new", data, 32'h2);

        // Long backpressure on both channels with new requests waiting
        s_awvalid = 1'b1; s_awaddr = 4'h4; s_wvalid = 1'b1; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF;
        s_arvalid = 1'b1; s_araddr = 4'h8;
        @(negedge clk);
        void'(modelWrite(4'h4, 32'h0BADF00D, 4'hF));
        heldData = model[2];
        s_awaddr = 4'h0; s_wdata = 32'hFFFFFFFF; s_araddr = 4'h0;
        for (int c = 0; c < 10; c++) begin
            checkOutput("stall_bvalid", s_bvalid, 1'b1);
            checkOutput("stall_bresp", s_bresp, 2'b00);
            checkOutput("stall_rvalid", s_rvalid, 1'b1);
            checkOutput("stall_rdata", s_rdata, heldData);
            checkOutput("stall_readies", {s_awready, s_wready, s_arready}, 3'b000);
            @(negedge clk);
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        checkOutput("stall_end_valids", {s_bvalid, s_rvalid}, 2'b00);
        checkOutput("stall_end_readies", {s_awready, s_wready, s_arready}, 3'b111);
        checkRegs("stall_regs");

        // Reset while both responses are pending
        s_awvalid = 1'b1; s_awaddr = 4'h0; s_wvalid = 1'b1; s_wdata = 32'h77; s_wstrb = 4'hF;
        s_arvalid = 1'b1; s_araddr = 4'h4;
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        checkOutput("pre_rst_valids", {s_bvalid, s_rvalid}, 2'b11);
        rstn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        checkOutput("midrst_valids", {s_bvalid, s_rvalid}, 2'b00);
        checkOutput("midrst_readies", {s_awready, s_wready, s_arready}, 3'b000);
        checkOutput("midrst_rdata", s_rdata, 32'h0);
        checkRegs("midrst_regs");
        s_bready = 1'b1; s_rready = 1'b1;
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rel_readies", {s_awready, s_wready, s_arready}, 3'b111);
        checkOutput("midrst_no_resp", {s_bvalid, s_rvalid}, 2'b00);
        s_bready = 1'b0; s_rready = 1'b0;

        // Randomized traffic against the array model
        for (int n = 0; n < 60; n++) begin
            addr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                data = $urandom;
                applyWrite(addr, data, 4'($urandom_range(0, 15)) , $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3), resp);
                expResp = modelWrite(addr, data, s_wstrb);
                checkOutput("rand_bresp", resp, expResp);
                checkRegs("rand_regs");
            end else begin
                idx     = int'(addr) / 4;
                expData = (idx < NREGS) ? model[idx] : 32'h0;
                expResp = (idx < NREGS) ? 2'b00 : 2'b10;
                applyRead(addr, $urandom_range(0, 3), $urandom_range(0, 3), data, resp);
                checkOutput("rand_rdata", data, expData);
                checkOutput("rand_rresp", resp, expResp);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
AXI4-Lite responder (slave) holding a small bank of 32-bit control registers. It accepts AW/W/AR transactions from the fabric-side AXI4-Lite initiator and returns B/R responses. Register contents go to fabric logic as a flat bus. It is the target end of the valid/ready initiators in this design.

Parameters:
ADDR_WIDTH, 4, byte-address width of awaddr/araddr.
DATA_WIDTH, 32, data width; fixed at 32 (4 strobe bits).
NUM_REGS, 4, number of RW registers; must be ≤ 2^(ADDR_WIDTH-2).

Ports:
clk  in  1  clock
rstn  in  1  reset, synchronous, active-low
s_awaddr  in  ADDR_WIDTH  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  byte enables
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  ADDR_WIDTH  read address
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
regs_out  out  NUM_REGS*32  register contents, reg i at bits [32*i+31:32*i]

Behaviour:
- Reset (rstn=0 at posedge): all registers 0, regs_out 0, all ready/valid outputs 0, bresp/rresp 00, rdata 0, both FSMs to IDLE. Reset mid-transaction abandons it; no response is issued afterwards.
- All outputs are registered. Handshake occurs at a posedge where valid&&ready.
- Decode: index = addr[ADDR_WIDTH-1:2]; addr[1:0] ignored. index ≥ NUM_REGS is an error.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: s_awready=1 until AW is captured; s_wready=1 until W is captured. AW and W are captured independently, in either order or in the same cycle. Captured fields are held.
  - On the edge where the second of AW/W is captured, or both together: the write commits at that same edge.
    - Valid index: each byte k updated only if wstrb[k]=1.
    - Invalid index: no register changes; response is SLVERR.
  - From that edge: awready=wready=0, bvalid=1, bresp set, state W_RESP.
  - W_RESP: bvalid and bresp held stable until bvalid&&bready, then return to W_IDLE with awready=wready=1 on the following cycle.
  - A second AW or W is not accepted before B completes (one outstanding write).
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1. On the AR handshake edge, rdata is loaded from the register contents before that edge; a write committing at the same edge is not visible.
  - Invalid index: rdata=0, rresp=SLVERR; otherwise rresp=OKAY.
  - From that edge: arready=0, rvalid=1, state R_DATA. Read latency is 1 cycle from the AR handshake.
  - R_DATA: rdata, rresp and rvalid held stable until rvalid&&rready, then R_IDLE with arready=1 the next cycle.
- Read and write paths are fully independent and may be active at the same time.
- After rstn deasserts: awready/wready/arready rise 1 cycle later.
- Backpressure: bready or rready held low indefinitely stalls only its own channel.

Test Plan:
1. AW(0x4) and W(0xDEADBEEF, strb 0xF) valid in the same cycle -> reg1=0xDEADBEEF at that edge; bvalid=1, bresp=00 next cycle; regs_out[63:32]=0xDEADBEEF.
2. W presented 3 cycles before AW(0x8), strb 0x3, data 0x12345678 on a reg2 holding 0xAAAAAAAA -> wready drops after W capture; reg2=0xAAAA5678 after AW capture; single B response.
3. Write to 0xC with NUM_REGS=3 -> bresp=10, no register change; read 0xC -> rdata=0, rresp=10.
4. AR(0x0) issued in the same cycle as a write commit to reg0 (old 0x1, new 0x2) -> rdata=0x1; a subsequent read returns 0x2.
5. bready and rready held low for 10 cycles -> bvalid/rvalid/data stay stable, awready/wready/arready stay 0, no new transaction is accepted.
6. rstn asserted while in W_RESP and R_DATA -> next cycle all valids 0, regs 0; readies return 1 cycle after rstn deasserts.
